// File: rtl/decoder_pkg.sv
// Shared types and constants for decoder_v3: opcode encodings, instruction
// classes, FSM states and ALU funct constants.
package decoder_pkg;

  typedef enum logic [6:0] {
    OP_S_TYPE = 7'b0000011,
    OP_I_TYPE = 7'b0010011,
    OP_R_TYPE = 7'b0110011,
    OP_U_LUI  = 7'b0110111
  } instr_type_e;

  typedef enum logic [2:0] {
    CLS_I,
    CLS_R,
    CLS_S,
    CLS_U,
    CLS_UDEF
  } instr_cls_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    EXECUTE = 2'd2
  } state_e;

  // funct3 of the shift-right group; only there does instr[30] select SRA/SRL
  localparam logic [2:0] FUNCT3_SRX = 3'b101;
  localparam logic [3:0] ALU_NOP    = 4'b0000;

  function automatic instr_cls_e classify(input logic [6:0] op);
    case (op)
      OP_I_TYPE: return CLS_I;
      OP_R_TYPE: return CLS_R;
      OP_S_TYPE: return CLS_S;
      OP_U_LUI:  return CLS_U;
      default:   return CLS_UDEF;
    endcase
  endfunction

endpackage

// File: rtl/decoder_fifo.sv
// Instruction queue for decoder_v3; pointers carry an extra wrap bit so
// full and empty are distinguished without a separate counter.
module decoder_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/decoder_v3.sv
// Queued instruction decoder with op_done watchdog. Optional illegal-opcode
// trapping is enabled by defining DECODER_ILLEGAL_TRAP_EN.
module decoder_v3
  import decoder_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int QDEPTH  = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [31:0]         instr,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic                op_done,
  output logic [3:0]          opcode,
  output logic [XLEN-1:0]     imme_data,
  output logic                rd2_imme_sel,
  output logic [3*REG_AW-1:0] rs1_rs2_rd,
  output logic                rs_addr_valid,
  output logic                rs_store,
  output logic                rd_wr_en,
  output logic                busy,
  output logic                timeout_err,
  output logic                illegal_instr
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e          state, state_nxt;
  logic [31:0]     instr_reg;
  logic [31:0]     q_head;
  logic            q_full, q_empty, q_push, q_pop;
  logic [CW-1:0]   wd_cnt;
  logic            wd_expire;

  instr_cls_e      cls;
  logic [2:0]      f3;
  logic [3:0]      opc_dec;
  logic [XLEN-1:0] imm_dec;
  logic            sel_dec, wr_dec, st_dec;
  logic [REG_AW-1:0] rs1_f;

  // no bypass: a full queue refuses the push even while popping
  assign q_push      = instr_valid && !q_full;
  assign instr_ready = !q_full;

  decoder_fifo #(
    .WIDTH(32),
    .DEPTH(QDEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (q_push),
    .pop    (q_pop),
    .din    (instr),
    .full   (q_full),
    .empty  (q_empty),
    .head   (q_head)
  );

  assign wd_expire = (TIMEOUT != 0) && (state == EXECUTE) && !op_done &&
                     (wd_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      instr_reg   <= '0;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      timeout_err <= wd_expire;
      if (q_pop) instr_reg <= q_head;
      // held at zero outside EXECUTE, so it starts cleared on every entry
      if (state != EXECUTE)  wd_cnt <= '0;
      else if (!op_done)     wd_cnt <= wd_cnt + 1'b1;
    end
  end

  always_comb begin
    cls     = classify(instr_reg[6:0]);
    f3      = instr_reg[14:12];
    opc_dec = ALU_NOP;
    imm_dec = '0;
    sel_dec = 1'b1;
    wr_dec  = 1'b0;
    st_dec  = 1'b0;
    case (cls)
      CLS_I: begin
        opc_dec = {instr_reg[30] & (f3 == FUNCT3_SRX), f3};
        imm_dec = XLEN'($signed(instr_reg[31:20]));
        sel_dec = 1'b0;
        wr_dec  = 1'b1;
      end
      CLS_R: begin
        opc_dec = {instr_reg[30], f3};
        wr_dec  = 1'b1;
      end
      CLS_S: begin
        imm_dec = XLEN'($signed({instr_reg[31:25], instr_reg[11:7]}));
        sel_dec = 1'b0;
        st_dec  = 1'b1;
      end
      CLS_U: begin
        imm_dec = XLEN'($signed({instr_reg[31:12], 12'b0}));
        sel_dec = 1'b0;
        wr_dec  = 1'b1;
      end
      default: ;
    endcase
    rs1_f = (cls == CLS_U) ? '0 : REG_AW'(instr_reg[19:15]);
  end

  always_comb begin
    state_nxt     = state;
    q_pop         = 1'b0;
    opcode        = ALU_NOP;
    imme_data     = '0;
    rd2_imme_sel  = 1'b1;
    rs1_rs2_rd    = '0;
    rs_addr_valid = 1'b0;
    rs_store      = 1'b0;
    rd_wr_en      = 1'b0;
    illegal_instr = 1'b0;
    case (state)
      IDLE: begin
        if (!q_empty) begin
          q_pop     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        state_nxt     = EXECUTE;
        rs_addr_valid = 1'b1;
        rs1_rs2_rd    = {rs1_f, REG_AW'(instr_reg[24:20]), REG_AW'(instr_reg[11:7])};
        rd2_imme_sel  = sel_dec;
        rd_wr_en      = wr_dec;
        rs_store      = st_dec;
        opcode        = opc_dec;
        imme_data     = imm_dec;
`ifdef DECODER_ILLEGAL_TRAP_EN
        if (cls == CLS_UDEF) begin
          state_nxt     = IDLE;
          rs_addr_valid = 1'b0;
          rs1_rs2_rd    = '0;
          rd_wr_en      = 1'b0;
          rs_store      = 1'b0;
          illegal_instr = 1'b1;
        end
`endif
      end
      EXECUTE: begin
        if (op_done || wd_expire) state_nxt = IDLE;
        rd2_imme_sel = sel_dec;
        rd_wr_en     = wr_dec;
        opcode       = opc_dec;
        imme_data    = imm_dec;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE) || !q_empty;

endmodule

// File: tb/tb_decoder_v3.sv
// Self-checking bench for decoder_v3: table-driven single issues, queue
// back-pressure, watchdog, undefined opcode and mid-operation reset.
module tb_decoder_v3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        op_done;
  logic [3:0]  opcode;
  logic [31:0] imme_data;
  logic        rd2_imme_sel;
  logic [14:0] rs1_rs2_rd;
  logic        rs_addr_valid;
  logic        rs_store;
  logic        rd_wr_en;
  logic        busy;
  logic        timeout_err;
  logic        illegal_instr;

  decoder_v3 #(
    .XLEN(32),
    .REG_AW(5),
    .QDEPTH(2),
    .TIMEOUT(16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .op_done      (op_done),
    .opcode       (opcode),
    .imme_data    (imme_data),
    .rd2_imme_sel (rd2_imme_sel),
    .rs1_rs2_rd   (rs1_rs2_rd),
    .rs_addr_valid(rs_addr_valid),
    .rs_store     (rs_store),
    .rd_wr_en     (rd_wr_en),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  opc;
    logic [31:0] imm;
    logic [14:0] regs;
    logic        sel;
    logic        wr;
    logic        st;
  } vec_t;

  vec_t v [9];
  vec_t v_udef;
  vec_t exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [14:0] regs3(input int rs1, input int rs2, input int rd);
    return {5'(rs1), 5'(rs2), 5'(rd)};
  endfunction

  // scoreboard: every ISSUE cycle is matched against the oldest expectation
  always @(negedge clk) begin
    if (reset_n && rs_addr_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_issue", 64'd1, 64'd0);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        chk("iss_opcode", 64'(opcode), 64'(e.opc));
        chk("iss_imm",    64'(imme_data), 64'(e.imm));
        chk("iss_regs",   64'(rs1_rs2_rd), 64'(e.regs));
        chk("iss_sel",    64'(rd2_imme_sel), 64'(e.sel));
        chk("iss_wr",     64'(rd_wr_en), 64'(e.wr));
        chk("iss_store",  64'(rs_store), 64'(e.st));
        chk("iss_illegal", 64'(illegal_instr), 64'd0);
      end
    end
  end

  task automatic push(input vec_t e, input bit expect_issue);
    int n;
    n = 0;
    instr       = e.instr;
    instr_valid = 1'b1;
    while (!instr_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) chk("push_accept_timeout", 64'd0, 64'd1);
    else if (expect_issue) exp_q.push_back(e);
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic wait_issue(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (rs_addr_valid || illegal_instr) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    op_done = 1'b1;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_idle", 64'(busy), 64'd0);
    op_done = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_opcode"},  64'(opcode), 64'd0);
    chk({tag, "_imm"},     64'(imme_data), 64'd0);
    chk({tag, "_sel"},     64'(rd2_imme_sel), 64'd1);
    chk({tag, "_regs"},    64'(rs1_rs2_rd), 64'd0);
    chk({tag, "_rav"},     64'(rs_addr_valid), 64'd0);
    chk({tag, "_store"},   64'(rs_store), 64'd0);
    chk({tag, "_wr"},      64'(rd_wr_en), 64'd0);
    chk({tag, "_busy"},    64'(busy), 64'd0);
    chk({tag, "_tmo"},     64'(timeout_err), 64'd0);
    chk({tag, "_illegal"}, 64'(illegal_instr), 64'd0);
    chk({tag, "_ready"},   64'(instr_ready), 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    bit ok;
    int ncyc;

    //          instr         opc    imm            regs {rs1,rs2,rd}  sel wr st
    v[0] = '{32'hFFB08193, 4'b0000, 32'hFFFFFFFB, regs3(1, 27, 3),  1'b0, 1'b1, 1'b0}; // ADDI x3,x1,-5
    v[1] = '{32'h40315113, 4'b1101, 32'h00000403, regs3(2, 3, 2),   1'b0, 1'b1, 1'b0}; // SRAI x2,x2,3
    v[2] = '{32'h800002B7, 4'b0000, 32'h80000000, regs3(0, 0, 5),   1'b0, 1'b1, 1'b0}; // LUI x5,0x80000
    v[3] = '{32'h00628233, 4'b0000, 32'h00000000, regs3(5, 6, 4),   1'b1, 1'b1, 1'b0}; // ADD x4,x5,x6
    v[4] = '{32'h402083B3, 4'b1000, 32'h00000000, regs3(1, 2, 7),   1'b1, 1'b1, 1'b0}; // SUB x7,x1,x2
    v[5] = '{32'hFE320C03, 4'b0000, 32'hFFFFFFF8, regs3(4, 3, 24),  1'b0, 1'b0, 1'b1}; // store-imm -8
    v[6] = '{32'h0010D093, 4'b0101, 32'h00000001, regs3(1, 1, 1),   1'b0, 1'b1, 1'b0}; // SRLI x1,x1,1
    v[7] = '{32'h40000093, 4'b0000, 32'h00000400, regs3(0, 0, 1),   1'b0, 1'b1, 1'b0}; // ADDI bit30, f3=000
    v[8] = '{32'h00A00513, 4'b0000, 32'h0000000A, regs3(0, 10, 10), 1'b0, 1'b1, 1'b0}; // ADDI x10,x0,10
    v_udef = '{32'h0000007F, 4'b0000, 32'h00000000, regs3(0, 0, 0), 1'b1, 1'b0, 1'b0};

    reset_n     = 1'b0;
    instr       = '0;
    instr_valid = 1'b0;
    op_done     = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset_n = 1'b1;
    @(negedge clk);

    // single issue of each table entry, acknowledged one cycle into EXECUTE
    for (int i = 0; i < 9; i++) begin
      push(v[i], 1'b1);
      wait_issue(ok);
      chk("issue_seen", 64'(ok), 64'd1);
      @(negedge clk);
      chk("exe_rav",   64'(rs_addr_valid), 64'd0);
      chk("exe_regs",  64'(rs1_rs2_rd), 64'd0);
      chk("exe_store", 64'(rs_store), 64'd0);
      chk("exe_wr",    64'(rd_wr_en), 64'(v[i].wr));
      chk("exe_sel",   64'(rd2_imme_sel), 64'(v[i].sel));
      chk("exe_busy",  64'(busy), 64'd1);
      op_done = 1'b1;
      @(negedge clk);
      op_done = 1'b0;
      chk("done_idle", 64'(busy), 64'd0);
    end

    // back-to-back pushes: first is popped at once, next two fill the queue
    push(v[3], 1'b1);
    push(v[4], 1'b1);
    push(v[5], 1'b1);
    chk("full_ready_low", 64'(instr_ready), 64'd0);
    instr       = v[6].instr;
    instr_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("full_hold_ready", 64'(instr_ready), 64'd0);
    end
    op_done = 1'b1;
    push(v[6], 1'b1);
    drain();

    // watchdog expiry after 16 EXECUTE cycles
    push(v[0], 1'b1);
    wait_issue(ok);
    chk("tmo_issue_seen", 64'(ok), 64'd1);
    ncyc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy && !rs_addr_valid) ncyc++;
      else break;
    end
    chk("tmo_exec_cycles", 64'(ncyc), 64'd16);
    chk("tmo_err_pulse",   64'(timeout_err), 64'd1);
    @(negedge clk);
    chk("tmo_err_cleared", 64'(timeout_err), 64'd0);

    // op_done on the 16th EXECUTE cycle wins over expiry
    push(v[0], 1'b1);
    wait_issue(ok);
    chk("tmo2_issue_seen", 64'(ok), 64'd1);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 16) begin
        chk("tmo2_still_exec", 64'(busy), 64'd1);
        op_done = 1'b1;
      end
    end
    @(negedge clk);
    op_done = 1'b0;
    chk("tmo2_idle",   64'(busy), 64'd0);
    chk("tmo2_no_err", 64'(timeout_err), 64'd0);
    @(negedge clk);
    chk("tmo2_no_err_late", 64'(timeout_err), 64'd0);

    // undefined opcode
`ifdef DECODER_ILLEGAL_TRAP_EN
    push(v_udef, 1'b0);
    wait_issue(ok);
    chk("udef_seen",        64'(ok), 64'd1);
    chk("udef_illegal",     64'(illegal_instr), 64'd1);
    chk("udef_rav",         64'(rs_addr_valid), 64'd0);
    chk("udef_wr",          64'(rd_wr_en), 64'd0);
    @(negedge clk);
    chk("udef_idle",        64'(busy), 64'd0);
    chk("udef_pulse_once",  64'(illegal_instr), 64'd0);
`else
    push(v_udef, 1'b1);
    wait_issue(ok);
    chk("udef_seen", 64'(ok), 64'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("udef_waits", 64'(busy), 64'd1);
      chk("udef_no_illegal", 64'(illegal_instr), 64'd0);
    end
    op_done = 1'b1;
    @(negedge clk);
    op_done = 1'b0;
    chk("udef_done_idle", 64'(busy), 64'd0);
`endif

    // asynchronous reset in EXECUTE with one instruction still queued
    push(v[0], 1'b1);
    push(v[1], 1'b1);
    @(negedge clk);
    chk("mid_exec_wr", 64'(rd_wr_en), 64'd1);
    chk("mid_exec_sel", 64'(rd2_imme_sel), 64'd0);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("arst");
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy",  64'(busy), 64'd0);
    chk("post_rst_ready", 64'(instr_ready), 64'd1);
    chk("post_rst_rav",   64'(rs_addr_valid), 64'd0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_v3.md
# decoder_v3

Parametrised successor instruction decoder for the single-issue core. Sits between the instruction memory and the register file / ALU. Adds three things over the single-instruction decoder:
- a small instruction queue with a valid/ready input handshake;
- LUI support and correct shift-immediate encoding;
- an op_done watchdog, plus optional illegal-instruction trapping.

## Interface
Parameters:
- XLEN, 32: datapath / immediate width; must be >= 32.
- REG_AW, 5: register address width.
- QDEPTH, 2: instruction queue depth; power of two, >= 2.
- TIMEOUT, 16: max EXECUTE cycles waiting for op_done; 0 disables the watchdog.

Ports:
- clk  in  1  single clock; everything on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- instr  in  32  instruction word.
- instr_valid  in  1  instr present.
- instr_ready  out  1  queue can accept; equals !full.
- op_done  in  1  ALU completion ack.
- opcode  out  4  ALU op {funct7[5], funct3}.
- imme_data  out  XLEN  sign-extended immediate.
- rd2_imme_sel  out  1  0 = immediate, 1 = rs2.
- rs1_rs2_rd  out  3*REG_AW  {rs1, rs2, rd}.
- rs_addr_valid  out  1  register file latches addresses.
- rs_store  out  1  custom store-immediate-to-rd.
- rd_wr_en  out  1  rd write enable.
- busy  out  1  state != IDLE or queue not empty.
- timeout_err  out  1  one-cycle watchdog pulse.
- illegal_instr  out  1  one-cycle pulse (DECODER_ILLEGAL_TRAP_EN only).

## Operation
- **Queue:**
  - Push on instr_valid && instr_ready.
  - Pop only in IDLE when not empty; the popped head is latched into instr_reg.
  - No bypass when full: a push is refused even in the same cycle as a pop.
- **Opcode classes** (instr[6:0]):
  - 0010011 I_TYPE
  - 0110011 R_TYPE
  - 0000011 S_TYPE (custom store-immediate)
  - 0110111 U_LUI
  - else UDEF
- **opcode output:**
  - R_TYPE: {instr[30], instr[14:12]}.
  - I_TYPE: {instr[30] & (funct3==101), funct3}.
  - U_LUI: 0000.
  - UDEF: 0000.
- **imme_data:**
  - I_TYPE: sext(instr[31:20]).
  - S_TYPE: sext({instr[31:25], instr[11:7]}).
  - U_LUI: sext({instr[31:12], 12'b0}).
  - R_TYPE / UDEF: 0.
- **FSM:**
  - IDLE → ISSUE when the queue is not empty (pop).
  - ISSUE → EXECUTE unconditionally.
  - EXECUTE → IDLE on op_done or watchdog expiry.
- **Outputs by state:**
  - IDLE: all controls 0, rd2_imme_sel = 1.
  - ISSUE: rs_addr_valid = 1; rs1_rs2_rd = {instr[19:15], instr[24:20], instr[11:7]}, with the rs1 field forced to 0 for U_LUI.
  - ISSUE, I_TYPE: sel 0, store 0, wr 1.
  - ISSUE, S_TYPE: sel 0, store 1, wr 0.
  - ISSUE, R_TYPE: sel 1, store 0, wr 1.
  - ISSUE, U_LUI: sel 0, store 0, wr 1.
  - ISSUE, UDEF: sel 1, store 0, wr 0.
  - EXECUTE: rs_addr_valid 0, rs1_rs2_rd 0, rs_store 0; rd2_imme_sel and rd_wr_en hold their ISSUE values.
- **Watchdog:**
  - Counter clears on entering EXECUTE and increments each EXECUTE cycle without op_done.
  - At count == TIMEOUT-1 without op_done: return to IDLE; timeout_err is registered high for the first IDLE cycle.
  - op_done in the same cycle as expiry: op_done wins, no error.
- **Reset (asynchronous, mid-operation allowed):**
  - Queue is emptied, state goes to IDLE, counter clears.
  - All outputs go to 0 except rd2_imme_sel = 1 and instr_ready = 1.

## Timing
- Push at edge E0.
- IDLE pops at E1.
- ISSUE (rs_addr_valid high) for exactly one cycle, E1–E2.
- EXECUTE from E2.
- op_done sampled at edge Ek gives IDLE in cycle Ek–Ek+1; the next queued instruction is popped at Ek+1.
- Back-to-back throughput is 3 cycles per instruction plus the op_done wait.
- instr_ready is combinational from the queue count; it does not depend on instr_valid.

## Configuration
- DECODER_ILLEGAL_TRAP_EN defined:
  - UDEF in ISSUE asserts illegal_instr, holds rs_addr_valid = 0 and all enables 0.
  - The FSM returns ISSUE → IDLE, skipping EXECUTE.
- Undefined:
  - illegal_instr is tied to 0.
  - UDEF is issued as a NOP: rs_addr_valid = 1, wr/store 0, opcode 0.
  - The FSM waits in EXECUTE for op_done or the watchdog as normal.

## Structure
- Package decoder_pkg:
  - instr_type_e (7-bit opcode encodings);
  - state_e {IDLE, ISSUE, EXECUTE};
  - ALU funct constants.
- Sub-module decoder_fifo:
  - parametrised by width 32 and depth QDEPTH;
  - ports push, pop, full, empty, head;
  - pointer wrap via extra MSB.

## Test plan
- Single ADDI x3, x1, -5 (0xFFB08193) → ISSUE cycle: rs1_rs2_rd = {1, 27, 3}, imme_data = 0xFFFFFFFB, rd2_imme_sel 0, rd_wr_en 1, opcode 0000.
- SRAI x2, x2, 3 (0x40315113) → opcode 1101, rd2_imme_sel 0. LUI x5, 0x80000 (0x800002B7) → imme_data = 0x80000000, rs1 field 0, rd_wr_en 1.
- Push 3 instructions back-to-back with op_done held low → instr_ready drops after 2 stored (QDEPTH=2); the third is accepted only once IDLE pops.
- Hold op_done low, TIMEOUT=16 → state returns to IDLE after 16 EXECUTE cycles with a one-cycle timeout_err. op_done asserted on cycle 16 → no timeout_err.
- Opcode 0x7F with the macro defined → illegal_instr pulse, rs_addr_valid stays 0, IDLE two cycles after the pop. Without the macro → NOP issue, then wait for op_done.
- Assert reset_n low during EXECUTE with 1 instruction queued → outputs at reset values immediately; busy 0, queue empty after release.
